timer_irq_ctrl: RTL

//  Configures and services NCH instances of the 32-bit interval counter.
//  - Config FSM: turns CPU config writes into one-cycle set/int_disable pulses on the counters.
//  - Interrupt FSM: latches each counter's c_int and presents one prioritised request to the CPU, with an ack handshake.
//  - Sits between the CPU register bus and the counter bank.

---
 rtl/timer_irq_ctrl_pkg.sv | 23 ++
 rtl/prio_enc_lo.sv | 23 ++
 rtl/timer_irq_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/timer_irq_ctrl_pkg.sv
// Shared types for the timer interrupt controller: config op codes and FSM state encodings.
package timer_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_DISABLE = 2'b01,
    OP_MASK    = 2'b10,
    OP_UNMASK  = 2'b11
  } cfg_op_t;

  typedef enum logic [1:0] {
    CFG_IDLE   = 2'b00,
    CFG_ISSUE  = 2'b01,
    CFG_SETTLE = 2'b10
  } cfg_state_t;

  typedef enum logic [1:0] {
    IRQ_IDLE     = 2'b00,
    IRQ_WAIT_ACK = 2'b01,
    IRQ_GAP      = 2'b10
  } irq_state_t;

endpackage

// File: rtl/prio_enc_lo.sv
// Lowest-index-first priority encoder: index of the lowest set request bit plus a valid flag.
module prio_enc_lo #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx_c,
  output logic          valid_c
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_c   = IW'(i);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Config sequencer and prioritised interrupt front-end for a bank of NCH interval counters.
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 32,
  parameter int unsigned IW  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_we,
  input  logic [IW-1:0]  cfg_ch,
  input  logic [1:0]     cfg_op,
  input  logic [W-1:0]   cfg_val,
  output logic           cfg_busy,
  output logic [NCH-1:0] cnt_set,
  output logic [NCH-1:0] cnt_dis,
  output logic [W-1:0]   cnt_val,
  input  logic [NCH-1:0] cnt_int,
  output logic           irq,
  output logic [IW-1:0]  irq_id,
  input  logic           irq_ack,
  output logic [NCH-1:0] pending
);

  localparam logic [NCH-1:0] ONE = NCH'(1);

  cfg_state_t     cfg_state, cfg_next;
  irq_state_t     irq_state, irq_next;
  cfg_op_t        lat_op;
  logic [IW-1:0]  lat_ch;
  logic [NCH-1:0] mask, int_q;

  cfg_op_t        op_c;
  logic           accept_c, start_c;
  logic           busy_d;
  logic [NCH-1:0] set_d, dis_d, rise_c, clr_c;
  logic [W-1:0]   val_d;
  logic           irq_d;
  logic [IW-1:0]  irq_id_d, sel_idx_c;
  logic           sel_valid_c;

  assign op_c     = cfg_op_t'(cfg_op);
  assign accept_c = cfg_we && (cfg_state == CFG_IDLE);
  assign start_c  = accept_c && ((op_c == OP_LOAD) || (op_c == OP_DISABLE));
  assign rise_c   = cnt_int & ~int_q;

  prio_enc_lo #(.N(NCH), .IW(IW)) u_prio (
    .req     (pending & ~mask),
    .idx_c   (sel_idx_c),
    .valid_c (sel_valid_c)
  );

  // Config FSM: state register, next state, registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cfg_state <= CFG_IDLE;
    else        cfg_state <= cfg_next;
  end

  always_comb begin
    cfg_next = cfg_state;
    case (cfg_state)
      CFG_IDLE:   if (start_c) cfg_next = CFG_ISSUE;
      CFG_ISSUE:  cfg_next = CFG_SETTLE;
      CFG_SETTLE: cfg_next = CFG_IDLE;
      default:    cfg_next = CFG_IDLE;
    endcase
  end

  always_comb begin
    set_d  = '0;
    dis_d  = '0;
    val_d  = cnt_val;
    busy_d = (cfg_next != CFG_IDLE);
    if (start_c) begin
      val_d = cfg_val;
      if (op_c == OP_LOAD) set_d = ONE << cfg_ch;
      else                 dis_d = ONE << cfg_ch;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_set  <= '0;
      cnt_dis  <= '0;
      cnt_val  <= '0;
      cfg_busy <= 1'b0;
      lat_op   <= OP_LOAD;
      lat_ch   <= '0;
      mask     <= '1;
    end else begin
      cnt_set  <= set_d;
      cnt_dis  <= dis_d;
      cnt_val  <= val_d;
      cfg_busy <= busy_d;
      if (start_c) begin
        lat_op <= op_c;
        lat_ch <= cfg_ch;
      end
      if (accept_c && (op_c == OP_MASK))   mask[cfg_ch] <= 1'b1;
      if (accept_c && (op_c == OP_UNMASK)) mask[cfg_ch] <= 1'b0;
    end
  end

  // Pending capture: edge-detect c_int; a new rise beats a same-cycle clear.
  always_comb begin
    clr_c = '0;
    if ((cfg_state == CFG_ISSUE) && (lat_op == OP_DISABLE)) clr_c[lat_ch] = 1'b1;
    if ((irq_state == IRQ_WAIT_ACK) && irq_ack)             clr_c[irq_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_q   <= '0;
      pending <= '0;
    end else begin
      int_q   <= cnt_int;
      pending <= (pending & ~clr_c) | rise_c;
    end
  end

  // Interrupt FSM: state register, next state, registered request outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_state <= IRQ_IDLE;
    else        irq_state <= irq_next;
  end

  always_comb begin
    irq_next = irq_state;
    case (irq_state)
      IRQ_IDLE:     if (sel_valid_c) irq_next = IRQ_WAIT_ACK;
      IRQ_WAIT_ACK: if (irq_ack) irq_next = IRQ_GAP;
      IRQ_GAP:      irq_next = IRQ_IDLE;
      default:      irq_next = IRQ_IDLE;
    endcase
  end

  always_comb begin
    irq_d    = (irq_next == IRQ_WAIT_ACK);
    irq_id_d = irq_id;
    if ((irq_state == IRQ_IDLE) && sel_valid_c) irq_id_d = sel_idx_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      irq    <= irq_d;
      irq_id <= irq_id_d;
    end
  end

endmodule
